mem_block_responder: RTL and testbench

Block-granular memory responder that sits on the far side of the cache memory interface. It accepts one 128-bit block read or write request at a time and stores blocks in an internal array. It answers each request after a fixed, parameterised latency with a single-cycle `mem_ready` pulse. It serves as the behavioural main memory behind the read-only and write-back caches in simulation and on FPGA.

---
 rtl/mem_block_if.sv | 20 ++
 rtl/mem_block_responder.sv | 94 +++++++++
 tb/tb_mem_block_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_block_if.sv
// Block memory bus between a cache (master) and the memory responder (slave).
// One 128-bit block per transfer; mem_read/mem_write are levels held until mem_ready.
interface mem_block_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder behind the cache memory interface.
// One request at a time; answers LATENCY+1 cycles after acceptance with a single
// mem_ready pulse. Define MEM_WRITE_EN to make the array writable; without it the
// block is a zero-initialised ROM that still accepts and acknowledges writes.
module mem_block_responder #(
    parameter int unsigned LATENCY = 8,
    parameter int unsigned DEPTH_W = 8
) (
    input logic       clk,
    input logic       proc_reset,
    mem_block_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    state_t               state;
    logic [7:0]           count;
    logic [DEPTH_W-1:0]   idx;
    logic                 op_write;
    logic [127:0]         array [2**DEPTH_W];

    // Upper address bits alias onto the stored blocks.
    logic unused_addr;
    assign unused_addr = ^bus.mem_addr[27:DEPTH_W];

`ifdef MEM_WRITE_EN
    logic [127:0] wdata_hold;
`else
    logic unused_wdata;
    assign unused_wdata = ^bus.mem_wdata;
`endif

    // Request FSM, latency counter, registered outputs and the block array.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state         <= S_IDLE;
            count         <= 8'd0;
            idx           <= '0;
            op_write      <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
`ifdef MEM_WRITE_EN
            wdata_hold    <= '0;
`endif
            for (int i = 0; i < 2**DEPTH_W; i++) begin
                array[i] <= '0;
            end
        end else begin
            bus.mem_ready <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        idx   <= bus.mem_addr[DEPTH_W-1:0];
                        count <= LOAD;
                        state <= S_BUSY;
`ifdef MEM_WRITE_EN
                        // A simultaneous read is dropped in favour of the write.
                        op_write   <= bus.mem_write;
                        wdata_hold <= bus.mem_wdata;
`else
                        // ROM: a simultaneous read wins so the data is returned.
                        op_write   <= bus.mem_write & ~bus.mem_read;
`endif
                    end
                end
                S_BUSY: begin
                    if (count == 8'd0) begin
                        state         <= S_RESP;
                        bus.mem_ready <= 1'b1;
                        if (!op_write) begin
                            bus.mem_rdata <= array[idx];
                        end
`ifdef MEM_WRITE_EN
                        else begin
                            array[idx] <= wdata_hold;
                        end
`endif
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench for mem_block_responder: directed vector table, hand-written
// busy/reset sequences, and randomized traffic against a block-array model.
module tb_mem_block_responder;

    localparam int unsigned LATENCY = 8;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned NBLK    = 2**DEPTH_W;
`ifdef MEM_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic clk = 1'b0;
    logic proc_reset = 1'b1;

    mem_block_if bus ();

    mem_block_responder #(.LATENCY(LATENCY), .DEPTH_W(DEPTH_W)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: block contents and the last data the responder returned.
    logic [127:0] model_mem [NBLK];
    logic [127:0] model_rdata;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBLK; i++) model_mem[i] = '0;
        model_rdata = '0;
    endtask

    task automatic model_apply(input bit rd, input bit wr, input logic [27:0] addr,
                               input logic [127:0] wd);
        int unsigned b;
        b = int'(addr) % NBLK;
        if (WE && wr) model_mem[b] = wd;
        else if (rd) model_rdata = model_mem[b];
    endtask

    // One transaction; checks response cycle and pulse width, returns mem_rdata at the pulse.
    task automatic req(input string name, input bit rd, input bit wr, input logic [27:0] addr,
                       input logic [127:0] wd, input bit junk, output logic [127:0] got);
        int n;
        bit seen;
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        n = 0;
        seen = 1'b0;
        while (!seen && n < int'(LATENCY) + 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_ready) begin
                seen = 1'b1;
            end else if (junk && n == 2) begin
                bus.mem_addr  = 28'h4;
                bus.mem_write = 1'b1;
                bus.mem_wdata = {4{32'hDEADBEEF}};
            end
        end
        got = bus.mem_rdata;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        check({name, " ready_cycle"}, seen ? 128'(n) : 128'(-1), 128'(LATENCY + 1));
        @(negedge clk);
        check({name, " pulse_width"}, 128'(bus.mem_ready), 128'(0));
    endtask

    typedef struct {
        bit           rd;
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_we;
        logic [127:0] exp_rom;
    } vec_t;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = 128'hAAAA0000AAAA1111AAAA2222AAAA3333;
    localparam logic [127:0] DB = 128'hBBBB4444BBBB5555BBBB6666BBBB7777;
    localparam logic [127:0] DC = 128'hCCCC8888CCCC9999CCCCAAAACCCCBBBB;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] exp;
        bit quiet;

        vecs[0] = '{1'b1, 1'b0, 28'h0000005, '0, '0, '0};
        vecs[1] = '{1'b0, 1'b1, 28'h0000012, D1, '0, '0};
        vecs[2] = '{1'b1, 1'b0, 28'h0000012, '0, D1, '0};
        vecs[3] = '{1'b0, 1'b1, 28'h0000112, DA, D1, '0};
        vecs[4] = '{1'b1, 1'b0, 28'h0000012, '0, DA, '0};
        vecs[5] = '{1'b0, 1'b1, 28'h0000009, DB, DA, '0};
        vecs[6] = '{1'b1, 1'b0, 28'h0000009, '0, DB, '0};
        vecs[7] = '{1'b1, 1'b1, 28'h0000020, DC, DB, '0};
        vecs[8] = '{1'b1, 1'b0, 28'h0000020, '0, DC, '0};

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        model_reset();

        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        check("reset ready", 128'(bus.mem_ready), 128'(0));
        check("reset rdata", bus.mem_rdata, '0);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                1'b0, got);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rdata", i), got, WE ? vecs[i].exp_we : vecs[i].exp_rom);
        end

        // Address/data/write changes while busy must not affect the read of 0x12
        req("busy_junk", 1'b1, 1'b0, 28'h0000012, '0, 1'b1, got);
        model_apply(1'b1, 1'b0, 28'h0000012, '0);
        check("busy_junk rdata", got, model_rdata);
        quiet = 1'b1;
        for (int i = 0; i < int'(LATENCY) + 3; i++) begin
            @(negedge clk);
            if (bus.mem_ready) quiet = 1'b0;
        end
        check("busy_junk single_pulse", 128'(quiet), 128'(1));
        req("busy_junk rd4", 1'b1, 1'b0, 28'h0000004, '0, 1'b0, got);
        model_apply(1'b1, 1'b0, 28'h0000004, '0);
        check("busy_junk array_unchanged", got, model_rdata);

        // Reset in cycle 4 of a write to 0x7 aborts it and clears everything
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000007;
        bus.mem_wdata = DC;
        quiet = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (bus.mem_ready) quiet = 1'b0;
        end
        proc_reset    = 1'b1;
        bus.mem_write = 1'b0;
        #1;
        check("abort ready_in_reset", 128'(bus.mem_ready), 128'(0));
        check("abort rdata_in_reset", bus.mem_rdata, '0);
        model_reset();
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < int'(LATENCY) + 3; i++) begin
            @(negedge clk);
            if (bus.mem_ready) quiet = 1'b0;
        end
        check("abort no_ready", 128'(quiet), 128'(1));
        req("abort rd7", 1'b1, 1'b0, 28'h0000007, '0, 1'b0, got);
        check("abort rd7 rdata", got, '0);
        req("abort rd9", 1'b1, 1'b0, 28'h0000009, '0, 1'b0, got);
        check("abort rd9 rdata", got, '0);

        // Randomized traffic with aliasing upper bits and occasional busy-phase noise
        for (int i = 0; i < 40; i++) begin
            int unsigned kind;
            bit rd;
            bit wr;
            bit junk;
            logic [27:0]  addr;
            logic [127:0] wd;
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            junk = ($urandom_range(0, 3) == 0);
            addr = 28'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
            wd   = {$urandom, $urandom, $urandom, $urandom};
            req($sformatf("rnd%0d", i), rd, wr, addr, wd, junk, got);
            model_apply(rd, wr, addr, wd);
            exp = model_rdata;
            check($sformatf("rnd%0d rdata", i), got, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
